// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry and writeback types for the writeback arbiter.
// Mirrors the REGADDR/WORD/NUM_REGS/WB_PORTS values of the core configuration.
package regfile_wb_arbiter_pkg;
    localparam int REGADDR  = 4;
    localparam int WORD     = 32;
    localparam int NUM_REGS = 16;
    localparam int WB_PORTS = 2;

    typedef logic [REGADDR-1:0] regaddr_t;
    typedef logic [WORD-1:0]    word_t;

    typedef struct packed {
        logic     wen;
        regaddr_t addr;
        word_t    din;
    } wb_port_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input regaddr_t a);
        return NUM_REGS'(1) << a;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write port and issue/scoreboard bundle.
// The arbiter sits on the slave side; requesters and issue stage on the master side.
interface regfile_wb_arbiter_if #(parameter int NUM_REQ = 3);
    import regfile_wb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*REGADDR-1:0] req_addr;
    logic [NUM_REQ*WORD-1:0]    req_data;
    logic                       wen_a;
    logic                       wen_b;
    regaddr_t                   addr_a;
    regaddr_t                   addr_b;
    word_t                      din_a;
    word_t                      din_b;
    logic                       iss_valid;
    regaddr_t                   iss_addr;
    logic                       iss_ready;
    logic [NUM_REGS-1:0]        busy;

    modport master (
        output req_valid, req_addr, req_data, iss_valid, iss_addr,
        input  req_ready, wen_a, wen_b, addr_a, addr_b, din_a, din_b, iss_ready, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, iss_valid, iss_addr,
        output req_ready, wen_a, wen_b, addr_a, addr_b, din_a, din_b, iss_ready, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker; the B winner must not share
// the A winner's destination so same-register writes stay in arbitration order.
module regfile_wb_arbiter_rr_pick2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  regaddr_t           i_addr [NUM_REQ],
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_found_a,
    output logic               o_found_b,
    output logic [IDX_W-1:0]   o_idx_a,
    output logic [IDX_W-1:0]   o_idx_b
);
    int               w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_grant   = '0;
        o_found_a = 1'b0;
        o_found_b = 1'b0;
        o_idx_a   = '0;
        o_idx_b   = '0;
        w_sum     = 0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr < NUM_REQ and k < NUM_REQ, so one conditional subtract wraps
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_idx = IDX_W'(w_sum);
            if (i_valid[w_idx]) begin
                if (!o_found_a) begin
                    o_found_a      = 1'b1;
                    o_idx_a        = w_idx;
                    o_grant[w_idx] = 1'b1;
                end else if (!o_found_b && (i_addr[w_idx] != i_addr[o_idx_a])) begin
                    o_found_b      = 1'b1;
                    o_idx_b        = w_idx;
                    o_grant[w_idx] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: grants up to two requesters per cycle onto registered
// register-file write ports A/B and tracks a busy bit per destination register.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    regaddr_t            w_addr [NUM_REQ];
    word_t               w_data [NUM_REQ];
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_found_a;
    logic                w_found_b;
    logic [IDX_W-1:0]    w_idx_a;
    logic [IDX_W-1:0]    w_idx_b;
    logic [IDX_W-1:0]    w_last;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;

    logic [IDX_W-1:0]    r_rr_ptr;
    wb_port_t            r_port [WB_PORTS];
    logic [NUM_REGS-1:0] r_busy;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g] = bus.req_addr[g*REGADDR +: REGADDR];
        assign w_data[g] = bus.req_data[g*WORD +: WORD];
    end

    regfile_wb_arbiter_rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_valid   (bus.req_valid),
        .i_addr    (w_addr),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_grant),
        .o_found_a (w_found_a),
        .o_found_b (w_found_b),
        .o_idx_a   (w_idx_a),
        .o_idx_b   (w_idx_b)
    );

    assign bus.req_ready = w_grant;
    assign w_last        = w_found_b ? w_idx_b : w_idx_a;
    assign w_ptr_nxt     = (w_last == IDX_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;

    // Committing writes retire their destinations; A and B never share one.
    assign w_clr = (r_port[0].wen ? reg_mask(r_port[0].addr) : '0)
                 | (r_port[1].wen ? reg_mask(r_port[1].addr) : '0);
    assign bus.iss_ready = ~r_busy[bus.iss_addr];
    assign w_set = (bus.iss_valid && bus.iss_ready) ? reg_mask(bus.iss_addr) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_port[0] <= '0;
            r_port[1] <= '0;
            r_busy    <= '0;
        end else begin
            if (w_found_a) r_rr_ptr <= w_ptr_nxt;
            r_port[0].wen  <= w_found_a;
            r_port[0].addr <= w_found_a ? w_addr[w_idx_a] : '0;
            r_port[0].din  <= w_found_a ? w_data[w_idx_a] : '0;
            r_port[1].wen  <= w_found_b;
            r_port[1].addr <= w_found_b ? w_addr[w_idx_b] : '0;
            r_port[1].din  <= w_found_b ? w_data[w_idx_b] : '0;
            r_busy         <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.wen_a  = r_port[0].wen;
    assign bus.addr_a = r_port[0].addr;
    assign bus.din_a  = r_port[0].din;
    assign bus.wen_b  = r_port[1].wen;
    assign bus.addr_b = r_port[1].addr;
    assign bus.din_b  = r_port[1].din;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model with its own register file.
module tb_regfile_wb_arbiter;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus();

    regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External register file fed by the DUT write ports
    logic [31:0] rf [16] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.wen_a) rf[bus.addr_a] <= bus.din_a;
        if (bus.wen_b) rf[bus.addr_b] <= bus.din_b;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit [NR-1:0] p_valid;
    bit [3:0]    p_addr [NR];
    bit [31:0]   p_data [NR];
    int          m_ptr;
    bit          m_wa, m_wb;
    bit [3:0]    m_aa, m_ab;
    bit [31:0]   m_da, m_db;
    bit [15:0]   m_busy;
    bit [31:0]   m_rf [16];
    bit [15:0]   m_written;

    function automatic void model_arb(input bit [NR-1:0] v, input bit [3:0] a [NR], input int ptr,
                                      output bit [NR-1:0] g, output int ia, output int ib);
        int order[$];
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) order.push_back((ptr + k) % NR);
        g  = '0;
        ia = -1;
        ib = -1;
        if (order.size() > 0) begin
            ia    = order[0];
            g[ia] = 1'b1;
            for (int j = 1; j < order.size(); j++)
                if (ib < 0 && a[order[j]] != a[ia]) begin
                    ib    = order[j];
                    g[ib] = 1'b1;
                end
        end
    endfunction

    task automatic drive_pending();
        bus.req_valid = p_valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*4 +: 4]   = p_addr[i];
            bus.req_data[i*32 +: 32] = p_data[i];
        end
    endtask

    task automatic rand_cycle(input bit allow_new);
        bit [NR-1:0] g;
        int          ia, ib;
        bit [15:0]   clr, set;
        bit          iss_v;
        bit [3:0]    iss_a;
        for (int i = 0; i < NR; i++)
            if (allow_new && !p_valid[i] && $urandom_range(0, 3) != 0) begin
                p_valid[i] = 1'b1;
                p_addr[i]  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                p_data[i]  = $urandom;
            end
        iss_v = allow_new && ($urandom_range(0, 2) == 0);
        iss_a = 4'($urandom_range(0, 15));
        drive_pending();
        bus.iss_valid = iss_v;
        bus.iss_addr  = iss_a;
        #1;
        model_arb(p_valid, p_addr, m_ptr, g, ia, ib);
        check("rand_req_ready", 32'(bus.req_ready), 32'(g));
        check("rand_iss_ready", 32'(bus.iss_ready), 32'(!m_busy[iss_a]));
        check("rand_wen_a", 32'(bus.wen_a), 32'(m_wa));
        check("rand_wen_b", 32'(bus.wen_b), 32'(m_wb));
        if (m_wa) begin
            check("rand_addr_a", 32'(bus.addr_a), 32'(m_aa));
            check("rand_din_a", bus.din_a, m_da);
        end
        if (m_wb) begin
            check("rand_addr_b", 32'(bus.addr_b), 32'(m_ab));
            check("rand_din_b", bus.din_b, m_db);
        end
        check("rand_busy", 32'(bus.busy), 32'(m_busy));
        clr = '0;
        set = '0;
        if (m_wa) begin clr[m_aa] = 1'b1; m_rf[m_aa] = m_da; m_written[m_aa] = 1'b1; end
        if (m_wb) begin clr[m_ab] = 1'b1; m_rf[m_ab] = m_db; m_written[m_ab] = 1'b1; end
        if (iss_v && !m_busy[iss_a]) set[iss_a] = 1'b1;
        m_busy = (m_busy & ~clr) | set;
        m_wa = (ia >= 0);
        m_wb = (ib >= 0);
        if (ia >= 0) begin m_aa = p_addr[ia]; m_da = p_data[ia]; p_valid[ia] = 1'b0; end
        if (ib >= 0) begin m_ab = p_addr[ib]; m_db = p_data[ib]; p_valid[ib] = 1'b0; end
        if (ia >= 0) m_ptr = (((ib >= 0) ? ib : ia) + 1) % NR;
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit [2:0]  valid;
        bit [11:0] addrs;   // {a2, a1, a0}
        bit [2:0]  rdy;
        bit        wa;
        int        ia;
        bit        wb;
        int        ib;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cnt [NR];
        int gap [NR];
        int maxgap;

        tbl[0] = '{3'b001, {4'd0, 4'd0, 4'd3},  3'b001, 1'b1, 0, 1'b0, 0};
        tbl[1] = '{3'b111, {4'd4, 4'd2, 4'd1},  3'b011, 1'b1, 0, 1'b1, 1};
        tbl[2] = '{3'b011, {4'd0, 4'd5, 4'd5},  3'b001, 1'b1, 0, 1'b0, 0};
        tbl[3] = '{3'b111, {4'd6, 4'd5, 4'd5},  3'b101, 1'b1, 0, 1'b1, 2};
        tbl[4] = '{3'b110, {4'd9, 4'd8, 4'd7},  3'b110, 1'b1, 1, 1'b1, 2};
        tbl[5] = '{3'b000, {4'd1, 4'd2, 4'd3},  3'b000, 1'b0, 0, 1'b0, 0};
        tbl[6] = '{3'b100, {4'd10, 4'd0, 4'd0}, 3'b100, 1'b1, 2, 1'b0, 0};
        tbl[7] = '{3'b101, {4'd2, 4'd0, 4'd2},  3'b001, 1'b1, 0, 1'b0, 0};

        // Reset state
        idle_inputs();
        #2;
        check("rst_wen_a", 32'(bus.wen_a), 0);
        check("rst_wen_b", 32'(bus.wen_b), 0);
        check("rst_addr_a", 32'(bus.addr_a), 0);
        check("rst_din_a", bus.din_a, 0);
        check("rst_addr_b", 32'(bus.addr_b), 0);
        check("rst_din_b", bus.din_b, 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_iss_ready", 32'(bus.iss_ready), 1);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        do_reset();

        // Table vectors, each from rr_ptr = 0
        for (int v = 0; v < 8; v++) begin
            bit [31:0] d [NR];
            do_reset();
            for (int i = 0; i < NR; i++) d[i] = 32'hD0000000 | (v << 8) | i;
            bus.req_valid = tbl[v].valid;
            bus.req_addr  = tbl[v].addrs;
            for (int i = 0; i < NR; i++) bus.req_data[i*32 +: 32] = d[i];
            #1;
            check($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(tbl[v].rdy));
            tick();
            idle_inputs();
            #1;
            check($sformatf("vec%0d_wen_a", v), 32'(bus.wen_a), 32'(tbl[v].wa));
            check($sformatf("vec%0d_wen_b", v), 32'(bus.wen_b), 32'(tbl[v].wb));
            if (tbl[v].wa) begin
                check($sformatf("vec%0d_addr_a", v), 32'(bus.addr_a), 32'(tbl[v].addrs[tbl[v].ia*4 +: 4]));
                check($sformatf("vec%0d_din_a", v), bus.din_a, d[tbl[v].ia]);
            end
            if (tbl[v].wb) begin
                check($sformatf("vec%0d_addr_b", v), 32'(bus.addr_b), 32'(tbl[v].addrs[tbl[v].ib*4 +: 4]));
                check($sformatf("vec%0d_din_b", v), bus.din_b, d[tbl[v].ib]);
            end
        end

        // Single write with scoreboard release
        do_reset();
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 4'd3;
        #1;
        check("sw_iss_ready", 32'(bus.iss_ready), 1);
        tick();
        bus.iss_valid = 1'b0;
        check("sw_busy3_set", 32'(bus.busy[3]), 1);
        bus.req_valid = 3'b001;
        bus.req_addr[3:0]  = 4'd3;
        bus.req_data[31:0] = 32'hDEADBEEF;
        #1;
        check("sw_ready0", 32'(bus.req_ready), 32'b001);
        tick();
        idle_inputs();
        #1;
        check("sw_wen_a", 32'(bus.wen_a), 1);
        check("sw_addr_a", 32'(bus.addr_a), 3);
        check("sw_din_a", bus.din_a, 32'hDEADBEEF);
        check("sw_wen_b", 32'(bus.wen_b), 0);
        check("sw_busy3_c1", 32'(bus.busy[3]), 1);
        tick();
        check("sw_busy3_c2", 32'(bus.busy[3]), 0);
        check("sw_rf3", rf[3], 32'hDEADBEEF);

        // Round-robin pointer advance
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd4, 4'd2, 4'd1};
        bus.req_data  = {32'h44, 32'h22, 32'h11};
        #1;
        check("rr_c0_ready", 32'(bus.req_ready), 32'b011);
        tick();
        bus.req_valid = 3'b100;
        #1;
        check("rr_c1_ready", 32'(bus.req_ready), 32'b100);
        check("rr_c1_addr_a", 32'(bus.addr_a), 1);
        check("rr_c1_addr_b", 32'(bus.addr_b), 2);
        tick();
        bus.req_valid = 3'b111;
        #1;
        check("rr_c2_ready", 32'(bus.req_ready), 32'b011);
        check("rr_c2_addr_a", 32'(bus.addr_a), 4);
        check("rr_c2_wen_b", 32'(bus.wen_b), 0);
        tick();
        idle_inputs();

        // Same-destination ordering
        do_reset();
        bus.req_valid = 3'b011;
        bus.req_addr  = {4'd0, 4'd5, 4'd5};
        bus.req_data  = {32'h0, 32'h22, 32'h11};
        #1;
        check("sa_c0_ready", 32'(bus.req_ready), 32'b001);
        tick();
        bus.req_valid = 3'b010;
        #1;
        check("sa_c1_ready", 32'(bus.req_ready), 32'b010);
        check("sa_c1_din_a", bus.din_a, 32'h11);
        check("sa_c1_wen_b", 32'(bus.wen_b), 0);
        tick();
        idle_inputs();
        #1;
        check("sa_c2_addr_a", 32'(bus.addr_a), 5);
        check("sa_c2_din_a", bus.din_a, 32'h22);
        tick();
        check("sa_rf5", rf[5], 32'h22);

        // Issue stall on a pending destination
        do_reset();
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 4'd7;
        #1;
        check("is_ready0", 32'(bus.iss_ready), 1);
        tick();
        check("is_busy7", 32'(bus.busy[7]), 1);
        check("is_ready_stall", 32'(bus.iss_ready), 0);
        bus.iss_valid = 1'b0;
        bus.req_valid = 3'b001;
        bus.req_addr[3:0]  = 4'd7;
        bus.req_data[31:0] = 32'h77;
        #1;
        check("is_wb_grant", 32'(bus.req_ready), 32'b001);
        tick();
        bus.req_valid = '0;
        #1;
        check("is_t1_ready", 32'(bus.iss_ready), 0);
        tick();
        check("is_t2_ready", 32'(bus.iss_ready), 1);

        // Asynchronous reset drops a staged write
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_addr[3:0]  = 4'd12;
        bus.req_data[31:0] = 32'hCAFE0012;
        bus.iss_valid = 1'b1;
        bus.iss_addr  = 4'd12;
        tick();
        idle_inputs();
        #1;
        check("ar_wen_a_pre", 32'(bus.wen_a), 1);
        check("ar_busy_pre", 32'(bus.busy[12]), 1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_wen_a", 32'(bus.wen_a), 0);
        check("ar_addr_a", 32'(bus.addr_a), 0);
        check("ar_din_a", bus.din_a, 0);
        check("ar_busy", 32'(bus.busy), 0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_rf12", rf[12], 32'h0);

        // Fairness with three distinct, always-valid requesters
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd4, 4'd2, 4'd1};
        bus.req_data  = {32'hA4, 32'hA2, 32'hA1};
        maxgap = 0;
        for (int i = 0; i < NR; i++) begin cnt[i] = 0; gap[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            #1;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) begin
                    cnt[i]++;
                    gap[i] = 0;
                end else begin
                    gap[i]++;
                    if (gap[i] > maxgap) maxgap = gap[i];
                end
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < NR; i++) check($sformatf("fair_cnt%0d", i), 32'(cnt[i]), 20);
        check("fair_maxgap_le1", 32'(maxgap <= 1), 1);

        // Randomized run against the reference model
        do_reset();
        p_valid = '0;
        m_ptr = 0;
        m_wa = 1'b0;
        m_wb = 1'b0;
        m_aa = '0; m_ab = '0; m_da = '0; m_db = '0;
        m_busy = '0;
        m_written = '0;
        for (int i = 0; i < NR; i++) begin p_addr[i] = '0; p_data[i] = '0; end
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 8; c++) rand_cycle(1'b0);
        for (int r = 0; r < 16; r++)
            if (m_written[r]) check($sformatf("rand_rf%0d", r), rf[r], m_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
